servo_cmd_decoder: RTL and testbench

SERVO_CMD_DECODER -- requirements
Module: servo_cmd_decoder

---
 rtl/servo_cmd_decoder_if.sv | 29 ++
 rtl/servo_cmd_decoder.sv | 153 +++++++++++++++
 tb/tb_servo_cmd_decoder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_cmd_decoder_if.sv
// Byte-stream and servo-status bundle for servo_cmd_decoder.
// master: the side that feeds UART bytes and watches the servo state.
// slave:  the decoder itself.
interface servo_cmd_decoder_if;
   logic       i_RX_DV;
   logic [7:0] i_RX_Byte;
   logic [3:0] o_LED_Value;
   logic [3:0] o_Target;
   logic       o_Busy;
   logic       o_Cmd_Err;

   modport master (
      output i_RX_DV,
      output i_RX_Byte,
      input  o_LED_Value,
      input  o_Target,
      input  o_Busy,
      input  o_Cmd_Err
   );

   modport slave (
      input  i_RX_DV,
      input  i_RX_Byte,
      output o_LED_Value,
      output o_Target,
      output o_Busy,
      output o_Cmd_Err
   );
endinterface

// File: rtl/servo_cmd_decoder.sv
// Servo command decoder: parses "P<hex>CR" from a UART byte stream and commits
// a 4-bit target position. Malformed or stalled commands raise a one-cycle error.
// Define SERVO_SLEW_EN to move the position one step per tick toward the target;
// without it the position follows the target on the same edge.
module servo_cmd_decoder #(
   parameter int unsigned TICK_CYCLES    = 1000000,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   servo_cmd_decoder_if.slave   bus
);

   typedef enum logic [1:0] {
      StIdle,
      StGotP,
      StGotDigit
   } state_e;

   localparam logic [7:0]  ChP         = 8'h50;
   localparam logic [7:0]  ChCr        = 8'h0D;
   localparam logic [7:0]  ChLf        = 8'h0A;
   localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  digit_q, digit_d;
   logic [3:0]  target_q, target_d;
   logic        err_q, err_d;
   logic [31:0] tmo_q, tmo_d;
   logic        hex_valid;
   logic [3:0]  hex_value;

   // ASCII hex digit decode, upper and lower case accepted.
   always_comb begin
      hex_valid = 1'b0;
      hex_value = 4'h0;
      if (bus.i_RX_Byte >= 8'h30 && bus.i_RX_Byte <= 8'h39) begin
         hex_valid = 1'b1;
         hex_value = 4'(bus.i_RX_Byte - 8'h30);
      end else if (bus.i_RX_Byte >= 8'h41 && bus.i_RX_Byte <= 8'h46) begin
         hex_valid = 1'b1;
         hex_value = 4'(bus.i_RX_Byte - 8'h37);
      end else if (bus.i_RX_Byte >= 8'h61 && bus.i_RX_Byte <= 8'h66) begin
         hex_valid = 1'b1;
         hex_value = 4'(bus.i_RX_Byte - 8'h57);
      end
   end

   // Parser next state, digit latch, commit, error pulse and inter-byte timeout.
   always_comb begin
      state_d  = state_q;
      digit_d  = digit_q;
      target_d = target_q;
      err_d    = 1'b0;
      tmo_d    = tmo_q;
      if (bus.i_RX_DV) begin
         // A byte always wins over a timeout landing in the same cycle.
         tmo_d = '0;
         unique case (state_q)
            StIdle: begin
               if (bus.i_RX_Byte == ChP) begin
                  state_d = StGotP;
               end else if (bus.i_RX_Byte != ChCr && bus.i_RX_Byte != ChLf) begin
                  err_d = 1'b1;
               end
            end
            StGotP: begin
               if (hex_valid) begin
                  digit_d = hex_value;
                  state_d = StGotDigit;
               end else if (bus.i_RX_Byte == ChP) begin
                  err_d = 1'b1;
               end else begin
                  state_d = StIdle;
                  err_d   = 1'b1;
               end
            end
            StGotDigit: begin
               if (bus.i_RX_Byte == ChCr) begin
                  target_d = digit_q;
                  state_d  = StIdle;
               end else if (bus.i_RX_Byte == ChP) begin
                  state_d = StGotP;
                  err_d   = 1'b1;
               end else begin
                  state_d = StIdle;
                  err_d   = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (state_q != StIdle) begin
         if (tmo_q == TimeoutLast) begin
            state_d = StIdle;
            err_d   = 1'b1;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 32'd1;
         end
      end
   end

   // Parser and command registers; reset drops any partial command at once.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q  <= StIdle;
         digit_q  <= 4'h0;
         target_q <= 4'h0;
         err_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         digit_q  <= digit_d;
         target_q <= target_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.o_Target  = target_q;
   assign bus.o_Cmd_Err = err_q;

`ifdef SERVO_SLEW_EN
   localparam logic [31:0] TickLast = 32'(TICK_CYCLES - 1);

   logic [31:0] tick_q;
   logic [3:0]  led_q;
   logic        tick_wrap;

   assign tick_wrap = (tick_q == TickLast);

   // Free-running tick; on each wrap the position moves one step toward the
   // current target, so a retarget mid-slew continues from where it is.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         tick_q <= '0;
         led_q  <= 4'h0;
      end else begin
         tick_q <= tick_wrap ? '0 : tick_q + 32'd1;
         if (tick_wrap && led_q != target_q) begin
            led_q <= (led_q < target_q) ? led_q + 4'd1 : led_q - 4'd1;
         end
      end
   end

   assign bus.o_LED_Value = led_q;
   assign bus.o_Busy      = (led_q != target_q);
`else
   assign bus.o_LED_Value = target_q;
   assign bus.o_Busy      = 1'b0;
`endif

endmodule

// File: tb/tb_servo_cmd_decoder.sv
// Directed bench for servo_cmd_decoder (TICK_CYCLES=4, TIMEOUT_CYCLES=20).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_servo_cmd_decoder;

   localparam int unsigned Tick = 4;
   localparam int unsigned Tmo  = 20;

   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   servo_cmd_decoder_if bus ();

   servo_cmd_decoder #(
      .TICK_CYCLES    (Tick),
      .TIMEOUT_CYCLES (Tmo)
   ) dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_l),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; presents one byte for exactly one rising edge.
   task automatic put(input logic [7:0] b);
      bus.i_RX_DV   = 1'b1;
      bus.i_RX_Byte = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.i_RX_DV   = 1'b0;
      bus.i_RX_Byte = 8'h00;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_pos(input string tag, input logic [3:0] tgt);
      chk({tag, "_target"}, 32'(bus.o_Target), 32'(tgt));
`ifndef SERVO_SLEW_EN
      chk({tag, "_led"}, 32'(bus.o_LED_Value), 32'(tgt));
      chk({tag, "_busy"}, 32'(bus.o_Busy), 32'd0);
`endif
   endtask

`ifdef SERVO_SLEW_EN
   task automatic wait_change(input logic [3:0] prev, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * Tick; i++) begin
         @(negedge clk);
         if (bus.o_LED_Value !== prev) begin
            ok = 1'b1;
            break;
         end
      end
   endtask
`endif

   initial begin
`ifdef SERVO_SLEW_EN
      logic       ok;
      logic [3:0] v;
`endif
      bus.i_RX_DV   = 1'b0;
      bus.i_RX_Byte = 8'h00;

      // Reset values
      #12;
      chk("rst_led", 32'(bus.o_LED_Value), 32'd0);
      chk("rst_target", 32'(bus.o_Target), 32'd0);
      chk("rst_busy", 32'(bus.o_Busy), 32'd0);
      chk("rst_err", 32'(bus.o_Cmd_Err), 32'd0);
      @(negedge clk);
      rst_l = 1'b1;

      // First byte lands on the first edge after reset release
      put(8'h50);
      chk("p_err", 32'(bus.o_Cmd_Err), 32'd0);
      put(8'h41);
      chk("a_err", 32'(bus.o_Cmd_Err), 32'd0);
      chk("a_target_hold", 32'(bus.o_Target), 32'd0);
      put(8'h0D);
      chk("pacr_err", 32'(bus.o_Cmd_Err), 32'd0);
      chk_pos("pacr", 4'hA);

      // Bad digit: one pulse on 'G', trailing CR ignored in idle
      put(8'h50);
      put(8'h47);
      chk("g_err", 32'(bus.o_Cmd_Err), 32'd1);
      idle(1);
      chk("g_err_clear", 32'(bus.o_Cmd_Err), 32'd0);
      put(8'h0D);
      chk("g_cr_err", 32'(bus.o_Cmd_Err), 32'd0);
      chk_pos("g", 4'hA);

      // Back-to-back junk in idle gives back-to-back pulses; LF is silent
      put(8'h58);
      chk("x_err", 32'(bus.o_Cmd_Err), 32'd1);
      put(8'h59);
      chk("y_err", 32'(bus.o_Cmd_Err), 32'd1);
      put(8'h0A);
      chk("lf_err", 32'(bus.o_Cmd_Err), 32'd0);
      idle(1);

      // Timeout after 20 idle cycles inside a command
      put(8'h50);
      idle(Tmo - 1);
      chk("tmo_early", 32'(bus.o_Cmd_Err), 32'd0);
      idle(1);
      chk("tmo_err", 32'(bus.o_Cmd_Err), 32'd1);
      idle(1);
      chk("tmo_err_clear", 32'(bus.o_Cmd_Err), 32'd0);
      put(8'h50);
      put(8'h35);
      put(8'h0D);
      chk("tmo_cmd_err", 32'(bus.o_Cmd_Err), 32'd0);
      chk_pos("tmo_cmd", 4'h5);

      // Byte on the very cycle the timeout would fire wins
      put(8'h50);
      idle(Tmo - 1);
      put(8'h37);
      chk("race_err", 32'(bus.o_Cmd_Err), 32'd0);
      put(8'h0D);
      chk("race_cr_err", 32'(bus.o_Cmd_Err), 32'd0);
      chk_pos("race", 4'h7);

      // Re-committing the same target is clean
      put(8'h50);
      put(8'h37);
      put(8'h0D);
      chk("same_err", 32'(bus.o_Cmd_Err), 32'd0);
      chk_pos("same", 4'h7);

      // 'P' after 'P' errors but restarts the command
      put(8'h50);
      put(8'h50);
      chk("pp_err", 32'(bus.o_Cmd_Err), 32'd1);
      put(8'h33);
      chk("pp_digit_err", 32'(bus.o_Cmd_Err), 32'd0);
      put(8'h0D);
      chk_pos("pp", 4'h3);

      // Junk where CR is expected: error, target held
      put(8'h50);
      put(8'h34);
      put(8'h5A);
      chk("z_err", 32'(bus.o_Cmd_Err), 32'd1);
      idle(1);
      chk_pos("z", 4'h3);

      // Lowercase hex digit
      put(8'h50);
      put(8'h62);
      put(8'h0D);
      chk("lc_err", 32'(bus.o_Cmd_Err), 32'd0);
      chk_pos("lc", 4'hB);

      // Asynchronous reset mid-command
      put(8'h50);
      put(8'h37);
      bus.i_RX_DV = 1'b0;
      #2 rst_l = 1'b0;
      #1;
      chk("arst_target", 32'(bus.o_Target), 32'd0);
      chk("arst_led", 32'(bus.o_LED_Value), 32'd0);
      chk("arst_busy", 32'(bus.o_Busy), 32'd0);
      chk("arst_err", 32'(bus.o_Cmd_Err), 32'd0);
      @(negedge clk);
      rst_l = 1'b1;
      put(8'h0D);
      chk("arst_cr_err", 32'(bus.o_Cmd_Err), 32'd0);
      chk_pos("arst_cr", 4'h0);
      put(8'h50);
      put(8'h39);
      put(8'h0D);
      chk_pos("arst_cmd", 4'h9);
      idle(1);

`ifdef SERVO_SLEW_EN
      // Slew from 0 to 3, one step per tick wrap
      rst_l = 1'b0;
      @(negedge clk);
      rst_l = 1'b1;
      put(8'h50);
      put(8'h33);
      put(8'h0D);
      idle(0);
      chk("slew_start_led", 32'(bus.o_LED_Value), 32'd0);
      chk("slew_start_busy", 32'(bus.o_Busy), 32'd1);
      for (int s = 1; s <= 3; s++) begin
         wait_change(4'(s - 1), ok);
         chk("slew_up_wait", 32'(ok), 32'd1);
         chk("slew_up_led", 32'(bus.o_LED_Value), 32'(s));
      end
      chk("slew_done_busy", 32'(bus.o_Busy), 32'd0);

      // Head for 15, reverse to 0 at position 8 without a jump
      put(8'h50);
      put(8'h46);
      put(8'h0D);
      idle(0);
      ok = 1'b0;
      for (int i = 0; i < 16 * Tick; i++) begin
         if (bus.o_LED_Value == 4'd8) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("slew_reach8", 32'(ok), 32'd1);
      put(8'h50);
      put(8'h30);
      put(8'h0D);
      idle(0);
      chk("slew_rev_target", 32'(bus.o_Target), 32'd0);
      v = bus.o_LED_Value;
      chk("slew_rev_busy", 32'(bus.o_Busy), 32'd1);
      while (v != 4'd0) begin
         wait_change(v, ok);
         chk("slew_down_wait", 32'(ok), 32'd1);
         chk("slew_down_led", 32'(bus.o_LED_Value), 32'(v - 4'd1));
         if (!ok) break;
         v = bus.o_LED_Value;
      end
      chk("slew_rev_done_busy", 32'(bus.o_Busy), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
